// File: rtl/conware_pkg.sv
// Shared types and helpers for the Game-of-Life run sequencer.
package conware_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } gen_state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_IN_FRAME  = 2'd1;
  localparam logic [1:0] ERR_OUT_FRAME = 2'd2;

  function automatic int unsigned frame_len(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/frame_beat_checker.sv
// Counts beats of one stream side and flags whether each frame closes with TLAST
// exactly on beat N-1.
module frame_beat_checker #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic fire,
  input  logic last,
  input  logic clr,
  output logic frame_ok,
  output logic frame_err
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] beat_q, beat_d;
  logic          final_beat;

  assign final_beat = (beat_q == CW'(N - 1));
  assign frame_ok   = fire & final_beat & last;
  assign frame_err  = fire & (last ^ final_beat);

  // A premature TLAST also restarts the count; the top discards the run anyway.
  always_comb begin
    beat_d = beat_q;
    if (clr)                       beat_d = '0;
    else if (fire && (final_beat || last)) beat_d = '0;
    else if (fire)                 beat_d = beat_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) beat_q <= '0;
    else       beat_q <= beat_d;
  end

endmodule

// File: rtl/conware_gen_sequencer.sv
// Run controller: admits num_gens frames into the engine, collects as many
// results, and checks framing on both sides.
module conware_gen_sequencer
  import conware_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned HEIGHT = 1,
  parameter int unsigned GEN_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [GEN_W-1:0]  num_gens,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [GEN_W-1:0]  gens_done,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  output logic              C_S_TVALID,
  input  logic              C_S_TREADY,
  output logic [DWIDTH-1:0] C_S_TDATA,
  output logic              C_S_TLAST,
  input  logic              C_M_TVALID,
  output logic              C_M_TREADY,
  input  logic [DWIDTH-1:0] C_M_TDATA,
  input  logic              C_M_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [DWIDTH-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST
);

  localparam int unsigned N = frame_len(WIDTH, HEIGHT);

  gen_state_t       state_q, state_d;
  logic [GEN_W-1:0] num_gens_q, num_gens_d;
  logic [GEN_W-1:0] frames_in_q, frames_in_d;
  logic [GEN_W-1:0] gens_done_q, gens_done_d;
  logic             in_open_q, in_open_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic out_open, in_fire, out_fire, start_ok, clr;
  logic in_ok, in_err, out_ok, out_err;

  assign out_open = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign in_fire  = S_AXIS_TVALID & C_S_TREADY & in_open_q;
  assign out_fire = C_M_TVALID & M_AXIS_TREADY & out_open;
  assign start_ok = start & ~abort & ((state_q == ST_IDLE) || (state_q == ST_ERR));
  assign clr      = start_ok | abort;

  assign C_S_TVALID    = S_AXIS_TVALID & in_open_q;
  assign S_AXIS_TREADY = C_S_TREADY & in_open_q;
  assign C_S_TDATA     = S_AXIS_TDATA;
  assign C_S_TLAST     = S_AXIS_TLAST;
  assign M_AXIS_TVALID = C_M_TVALID & out_open;
  assign C_M_TREADY    = M_AXIS_TREADY & out_open;
  assign M_AXIS_TDATA  = C_M_TDATA;
  assign M_AXIS_TLAST  = C_M_TLAST;

  frame_beat_checker #(.N(N)) u_in_chk (
    .clk(clk), .rstn(rstn), .fire(in_fire), .last(S_AXIS_TLAST), .clr(clr),
    .frame_ok(in_ok), .frame_err(in_err)
  );

  frame_beat_checker #(.N(N)) u_out_chk (
    .clk(clk), .rstn(rstn), .fire(out_fire), .last(C_M_TLAST), .clr(clr),
    .frame_ok(out_ok), .frame_err(out_err)
  );

  always_comb begin
    state_d     = state_q;
    num_gens_d  = num_gens_q;
    frames_in_d = frames_in_q;
    gens_done_d = gens_done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    if (abort) begin
      state_d     = ST_IDLE;
      frames_in_d = '0;
      gens_done_d = '0;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR: if (start) begin
          num_gens_d  = num_gens;
          frames_in_d = '0;
          gens_done_d = '0;
          err_d       = 1'b0;
          err_code_d  = ERR_NONE;
          state_d     = (num_gens == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN, ST_DRAIN: begin
          if (in_err || out_err) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = in_err ? ERR_IN_FRAME : ERR_OUT_FRAME;
          end else begin
            if (in_ok)  frames_in_d = frames_in_q + GEN_W'(1);
            if (out_ok) gens_done_d = gens_done_q + GEN_W'(1);
            // Completion wins even if the last input frame closes in the same cycle.
            if (gens_done_d == num_gens_q)      state_d = ST_DONE;
            else if (frames_in_d == num_gens_q) state_d = ST_DRAIN;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d    = (state_d == ST_DONE);
    in_open_d = (state_d == ST_RUN) && (frames_in_d < num_gens_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      num_gens_q  <= '0;
      frames_in_q <= '0;
      gens_done_q <= '0;
      in_open_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      num_gens_q  <= num_gens_d;
      frames_in_q <= frames_in_d;
      gens_done_q <= gens_done_d;
      in_open_q   <= in_open_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign gens_done = gens_done_q;

endmodule

// File: tb/tb_conware_gen_sequencer.sv
// Randomised bench: queue-based source/engine/sink model around the sequencer.
module tb_conware_gen_sequencer;

  localparam int DW = 32, W = 4, H = 1, GW = 16, N = W * H;

  logic          clk = 0, rstn = 1, start = 0, abort = 0;
  logic [GW-1:0] num_gens = '0;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [GW-1:0] gens_done;
  logic          S_AXIS_TVALID = 0, S_AXIS_TREADY, S_AXIS_TLAST = 0;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic          C_S_TVALID, C_S_TREADY = 0, C_S_TLAST;
  logic [DW-1:0] C_S_TDATA;
  logic          C_M_TVALID = 0, C_M_TREADY, C_M_TLAST = 0;
  logic [DW-1:0] C_M_TDATA = '0;
  logic          M_AXIS_TVALID, M_AXIS_TREADY = 0, M_AXIS_TLAST;
  logic [DW-1:0] M_AXIS_TDATA;

  conware_gen_sequencer #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .num_gens(num_gens),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .gens_done(gens_done),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
    .C_S_TVALID(C_S_TVALID), .C_S_TREADY(C_S_TREADY),
    .C_S_TDATA(C_S_TDATA), .C_S_TLAST(C_S_TLAST),
    .C_M_TVALID(C_M_TVALID), .C_M_TREADY(C_M_TREADY),
    .C_M_TDATA(C_M_TDATA), .C_M_TLAST(C_M_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in engine transform so results are distinguishable from inputs.
  function automatic logic [DW-1:0] eng_fn(input logic [DW-1:0] d);
    return {d[15:0], d[31:16]} ^ 32'hC0DE_0001;
  endfunction

  logic [DW-1:0] src_d[$], eng_d[$];
  bit            src_l[$], eng_l[$];
  int src_idx, out_idx, acc, exp_beats, cyc, stall_pct, rdy_pct;
  int done_cnt, done_cyc, err_cyc, first_acc_cyc, last_acc_cyc, last_out_cyc;
  int over_acc, held_cnt, gd_changes, gd_err, extra_out;
  bit busy_at_done, start_v = 0, abort_v = 0;
  logic [GW-1:0] gd_prev;

  task automatic tick();
    cyc++;
    @(negedge clk);
    start = start_v;
    abort = abort_v;
    if (src_idx < src_d.size() && $urandom_range(99) >= stall_pct) begin
      S_AXIS_TVALID = 1; S_AXIS_TDATA = src_d[src_idx]; S_AXIS_TLAST = src_l[src_idx];
    end else begin
      S_AXIS_TVALID = 0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 0;
    end
    C_S_TREADY = (eng_d.size() < 16);
    if (eng_d.size() > 0) begin
      C_M_TVALID = 1; C_M_TDATA = eng_d[0]; C_M_TLAST = eng_l[0];
    end else begin
      C_M_TVALID = 0; C_M_TDATA = '0; C_M_TLAST = 0;
    end
    M_AXIS_TREADY = ($urandom_range(99) < rdy_pct);
    #1;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    if (gens_done != gd_prev) begin
      gd_changes++;
      if (gens_done != gd_prev + GW'(1)) gd_err++;
      gd_prev = gens_done;
    end
    if (S_AXIS_TVALID && S_AXIS_TREADY) begin
      if (acc >= exp_beats) over_acc++;
      if (acc == 0) first_acc_cyc = cyc;
      acc++; src_idx++; last_acc_cyc = cyc;
    end else if (S_AXIS_TVALID && acc >= exp_beats) held_cnt++;
    if (C_S_TVALID && C_S_TREADY) begin
      eng_d.push_back(eng_fn(C_S_TDATA)); eng_l.push_back(C_S_TLAST);
    end
    if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      if (out_idx < exp_beats) begin
        chk("out_data", M_AXIS_TDATA, eng_fn(src_d[out_idx]));
        chk("out_last", M_AXIS_TLAST, src_l[out_idx]);
      end else extra_out++;
      out_idx++; last_out_cyc = cyc;
    end
    if (C_M_TVALID && C_M_TREADY) begin
      void'(eng_d.pop_front()); void'(eng_l.pop_front());
    end
  endtask

  // Builds ng+1 frames of source data (one spare frame to prove the gate
  // closes) and issues the start pulse.
  task automatic begin_run(input int ng, input int bad_idx, input int stall, input int rdy);
    src_d.delete(); src_l.delete(); eng_d.delete(); eng_l.delete();
    for (int k = 0; k < (ng + 1) * N; k++) begin
      src_d.push_back($urandom);
      src_l.push_back((k % N) == N - 1 || k == bad_idx);
    end
    exp_beats = ng * N;
    src_idx = 0; out_idx = 0; acc = 0;
    stall_pct = stall; rdy_pct = rdy;
    num_gens = GW'(ng);
    start_v = 1;
    tick();
    start_v = 0;
    cyc = 0; done_cnt = 0; done_cyc = -1; err_cyc = -1; first_acc_cyc = -1;
    last_acc_cyc = -1; last_out_cyc = -1; over_acc = 0; held_cnt = 0;
    gd_changes = 0; gd_err = 0; extra_out = 0; busy_at_done = 1; gd_prev = '0;
  endtask

  task automatic run_until(input int budget);
    while (done_cnt == 0 && err !== 1'b1 && cyc < budget) tick();
    chk("within_budget", cyc < budget, 1);
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rstn = 0;
    S_AXIS_TVALID = 1; C_S_TREADY = 1; C_M_TVALID = 1; M_AXIS_TREADY = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_gens_done", gens_done, 0);
    chk("rst_gates", {C_S_TVALID, S_AXIS_TREADY, M_AXIS_TVALID, C_M_TREADY}, 0);
    @(negedge clk) rstn = 1;

    // Three generations, no backpressure.
    begin_run(3, -1, 0, 100);
    run_until(200);
    chk("t1_first_accept_cyc", first_acc_cyc, 1);
    chk("t1_accepted", acc, 12);
    chk("t1_over_accept", over_acc, 0);
    chk("t1_13th_held", held_cnt > 0, 1);
    chk("t1_out_beats", out_idx, 12);
    chk("t1_gd_steps", {gd_changes[7:0], gd_err[7:0]}, {8'd3, 8'd0});
    chk("t1_gens_done", gens_done, 3);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_done_lat", done_cyc, last_out_cyc + 1);
    chk("t1_busy_at_done", busy_at_done, 0);
    chk("t1_err", err, 0);

    // Zero generations.
    begin_run(0, -1, 0, 100);
    run_until(50);
    chk("t2_done_cyc", done_cyc, 1);
    chk("t2_done_pulses", done_cnt, 1);
    chk("t2_accepted", acc, 0);
    chk("t2_err", err, 0);

    // Premature TLAST on the second input beat.
    begin_run(2, 1, 0, 100);
    run_until(50);
    chk("t3_err_code", {err, err_code}, 3'b101);
    chk("t3_err_lat", err_cyc, last_acc_cyc + 1);
    chk("t3_accepted", acc, 2);
    chk("t3_no_done", done_cnt, 0);
    chk("t3_gates", {busy, S_AXIS_TREADY, C_S_TVALID, C_M_TREADY, M_AXIS_TVALID}, 0);

    // Random stalls and sink backpressure; this start also clears the error.
    begin_run(5, -1, 30, 50);
    tick();
    chk("t4_err_cleared", {err, err_code}, 0);
    run_until(2000);
    chk("t4_out_beats", out_idx, 20);
    chk("t4_extra_out", extra_out, 0);
    chk("t4_accepted", acc, 20);
    chk("t4_over_accept", over_acc, 0);
    chk("t4_engine_empty", eng_d.size(), 0);
    chk("t4_gens_done", gens_done, 5);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_err", err, 0);

    // Abort mid-frame.
    begin_run(3, -1, 0, 100);
    repeat (6) tick();
    chk("t5_pre_gens_done", gens_done, 1);
    abort_v = 1;
    tick();
    abort_v = 0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_gates", {S_AXIS_TREADY, C_S_TVALID, C_M_TREADY, M_AXIS_TVALID}, 0);
    chk("t5_gens_done", gens_done, 0);
    chk("t5_err", err, 0);

    // Asynchronous reset while draining.
    begin_run(2, -1, 0, 0);
    while (acc < 8 && cyc < 100) tick();
    repeat (2) tick();
    S_AXIS_TVALID = 1; C_S_TREADY = 1; C_M_TVALID = 1; M_AXIS_TREADY = 1;
    #1;
    chk("t6_pre_drain", {busy, C_M_TREADY, S_AXIS_TREADY}, 3'b110);
    rstn = 0;
    #1;
    chk("t6_rst_status", {busy, done, err, err_code}, 0);
    chk("t6_rst_gens_done", gens_done, 0);
    chk("t6_rst_gates", {C_S_TVALID, S_AXIS_TREADY, M_AXIS_TVALID, C_M_TREADY}, 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    begin_run(2, -1, 0, 100);
    run_until(200);
    chk("t6_out_beats", out_idx, 8);
    chk("t6_gens_done", gens_done, 2);
    chk("t6_done_pulses", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
